// File: rtl/ahb_addr_decoder.sv
// AHB address-phase decoder for three slaves with a registered data-phase select
// and a built-in default slave that returns a two-cycle ERROR for unmapped transfers.
module ahb_addr_decoder #(
  parameter logic [31:0] S1_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000,
  parameter logic [31:0] S2_BASE = 32'h1000_0000,
  parameter logic [31:0] S2_MASK = 32'hF000_0000,
  parameter logic [31:0] S3_BASE = 32'h2000_0000,
  parameter logic [31:0] S3_MASK = 32'hF000_0000,
  parameter int          CNT_W   = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
  output logic [2:0]       HSEL,
  output logic [2:0]       HSEL_DP,
  output logic             HSEL_DEF_DP,
  output logic             HREADY_DEF,
  output logic [1:0]       HRESP_DEF,
  output logic [31:0]      HRDATA_DEF,
  output logic [CNT_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // Saturating increment: the event counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      sat_inc = val;
    end else begin
      sat_inc = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic             hit1_s;
  logic             hit2_s;
  logic             hit3_s;
  logic             miss_s;
  logic             def_req_s;
  logic [2:0]       hsel_s;
  logic [2:0]       hsel_dp_r;
  logic             hsel_def_dp_r;
  state_t           state_r;
  logic             hready_def_r;
  logic [1:0]       hresp_def_r;
  logic [CNT_W-1:0] err_cnt_r;

  // Priority address decode, independent of the transfer type.
  always_comb begin
    hit1_s    = ((HADDR & S1_MASK) == S1_BASE);
    hit2_s    = ((HADDR & S2_MASK) == S2_BASE);
    hit3_s    = ((HADDR & S3_MASK) == S3_BASE);
    hsel_s    = 3'b000;
    if (hit1_s) begin
      hsel_s = 3'b001;
    end else if (hit2_s) begin
      hsel_s = 3'b010;
    end else if (hit3_s) begin
      hsel_s = 3'b100;
    end else begin
      hsel_s = 3'b000;
    end
    miss_s    = ~(hit1_s | hit2_s | hit3_s);
    def_req_s = miss_s & HTRANS[1];
  end

  // Data-phase select pipeline, advanced only when the bus accepts an address phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hsel_dp_r     <= 3'b001;
      hsel_def_dp_r <= 1'b0;
    end else if (HREADY) begin
      hsel_dp_r     <= hsel_s;
      hsel_def_dp_r <= miss_s;
    end else begin
      hsel_dp_r     <= hsel_dp_r;
      hsel_def_dp_r <= hsel_def_dp_r;
    end
  end

  // Default-slave FSM; response outputs are registered alongside the next state.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r      <= ST_IDLE;
      hready_def_r <= 1'b1;
      hresp_def_r  <= RESP_OKAY;
      err_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_ERR2: begin
          if (HREADY && def_req_s) begin
            state_r      <= ST_ERR1;
            hready_def_r <= 1'b0;
            hresp_def_r  <= RESP_ERROR;
            err_cnt_r    <= sat_inc(err_cnt_r);
          end else begin
            state_r      <= ST_IDLE;
            hready_def_r <= 1'b1;
            hresp_def_r  <= RESP_OKAY;
            err_cnt_r    <= err_cnt_r;
          end
        end
        ST_ERR1: begin
          state_r      <= ST_ERR2;
          hready_def_r <= 1'b1;
          hresp_def_r  <= RESP_ERROR;
          err_cnt_r    <= err_cnt_r;
        end
        default: begin
          state_r      <= ST_IDLE;
          hready_def_r <= 1'b1;
          hresp_def_r  <= RESP_OKAY;
          err_cnt_r    <= err_cnt_r;
        end
      endcase
    end
  end

  assign HSEL        = hsel_s;
  assign HSEL_DP     = hsel_dp_r;
  assign HSEL_DEF_DP = hsel_def_dp_r;
  assign HREADY_DEF  = hready_def_r;
  assign HRESP_DEF   = hresp_def_r;
  assign HRDATA_DEF  = 32'h0000_0000;
  assign ERR_CNT     = err_cnt_r;

endmodule
